// File: rtl/fetch_queue.sv
// Circular instruction queue between fetch and dispatch.
// Holds {instr, PC, nPC}; back-pressures fetch when full, flushes on redirect.
module fetch_queue #(
  parameter int IQ_DEPTH     = 4,
  parameter int LOG_IQ_DEPTH = 2
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    from_fetch_ivalid,
  input  logic [31:0]             from_fetch_instr,
  input  logic [13:0]             from_fetch_PC,
  input  logic [13:0]             from_fetch_nPC,
  input  logic                    from_pipeline_take_resolved,
  input  logic                    dispatch_ready,
  output logic                    to_dispatch_valid,
  output logic [31:0]             to_dispatch_instr,
  output logic [13:0]             to_dispatch_PC,
  output logic [13:0]             to_dispatch_nPC,
  output logic                    stall_fetch,
  output logic [LOG_IQ_DEPTH:0]   occupancy,
  output logic                    DUT_error
);

  typedef logic [31:0] word_t;
  typedef logic [13:0] pc_t;

  typedef struct packed {
    word_t instr;
    pc_t   pc;
    pc_t   npc;
  } entry_t;

  localparam logic [LOG_IQ_DEPTH:0] FULL_CNT =
    (LOG_IQ_DEPTH+1)'(IQ_DEPTH);

  entry_t                  mem [IQ_DEPTH];
  logic [LOG_IQ_DEPTH-1:0] head;
  logic [LOG_IQ_DEPTH-1:0] tail;
  logic [LOG_IQ_DEPTH:0]   count;
  logic                    err;

  logic full;
  logic empty;
  logic flush;
  logic enq;
  logic deq;
  logic ovf;
  entry_t head_e;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign flush = from_pipeline_take_resolved;
  assign enq   = from_fetch_ivalid & ~full & ~flush;
  assign deq   = ~empty & dispatch_ready & ~flush;
  assign ovf   = from_fetch_ivalid & full & ~flush;

  assign head_e            = mem[head];
  assign to_dispatch_valid = ~empty;
  assign to_dispatch_instr = head_e.instr;
  assign to_dispatch_PC    = head_e.pc;
  assign to_dispatch_nPC   = head_e.npc;
  assign stall_fetch       = full;
  assign occupancy         = count;
  assign DUT_error         = err;

  // Entry storage: cleared on reset, written at tail on enqueue.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      for (int i = 0; i < IQ_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (enq) begin
      mem[tail] <= '{
        instr: from_fetch_instr,
        pc:    from_fetch_PC,
        npc:   from_fetch_nPC
      };
    end
  end

  // Pointers and count; flush empties the queue and suppresses traffic.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      unique case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // One-cycle error pulse when fetch pushes into a full queue.
  always_ff @(posedge CLK) begin
    if (nRST) err <= 1'b0;
    else      err <= ovf;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed, table-driven bench for fetch_queue.
// Rows give inputs for one edge and the outputs expected just after it.
module tb_fetch_queue;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ivalid;
  logic [31:0] instr;
  logic [13:0] pc;
  logic [13:0] npc;
  logic        take;
  logic        ready;
  logic        dvalid;
  logic [31:0] dinstr;
  logic [13:0] dpc;
  logic [13:0] dnpc;
  logic        stall;
  logic [2:0]  occ;
  logic        derr;

  int passed = 0;
  int total  = 0;

  fetch_queue #(.IQ_DEPTH(4), .LOG_IQ_DEPTH(2)) dut (
    .CLK                         (CLK),
    .nRST                        (nRST),
    .from_fetch_ivalid           (ivalid),
    .from_fetch_instr            (instr),
    .from_fetch_PC               (pc),
    .from_fetch_nPC              (npc),
    .from_pipeline_take_resolved (take),
    .dispatch_ready              (ready),
    .to_dispatch_valid           (dvalid),
    .to_dispatch_instr           (dinstr),
    .to_dispatch_PC              (dpc),
    .to_dispatch_nPC             (dnpc),
    .stall_fetch                 (stall),
    .occupancy                   (occ),
    .DUT_error                   (derr)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       nm;
    logic        rst;
    logic        iv;
    logic [13:0] pc;
    logic        take;
    logic        rdy;
    logic        ev;
    logic [13:0] epc;
    logic        est;
    logic [2:0]  eocc;
    logic        eerr;
  } vec_t;

  vec_t tv[$];

  function automatic logic [31:0] mk(input logic [13:0] p);
    return 32'h8C00FFF0 + {18'h0, p};
  endfunction

  function automatic vec_t v(
    input string nm, input logic rst, input logic iv,
    input logic [13:0] p, input logic tk, input logic rd,
    input logic ev, input logic [13:0] epc, input logic est,
    input logic [2:0] eocc, input logic eerr);
    vec_t r;
    r.nm = nm; r.rst = rst; r.iv = iv; r.pc = p;
    r.take = tk; r.rdy = rd; r.ev = ev; r.epc = epc;
    r.est = est; r.eocc = eocc; r.eerr = eerr;
    return r;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic rst, input logic iv,
                       input logic [13:0] p, input logic tk,
                       input logic rd);
    nRST = rst; ivalid = iv; pc = p;
    instr = mk(p); npc = p + 14'd1;
    take = tk; ready = rd;
  endtask

  task automatic check_head(input string nm, input logic [13:0] epc);
    cmp({nm, ".pc"}, 32'(dpc), 32'(epc));
    cmp({nm, ".instr"}, dinstr, mk(epc));
    cmp({nm, ".npc"}, 32'(dnpc), 32'(epc + 14'd1));
  endtask

  initial begin
    drive(1'b1, 1'b0, 14'h0, 1'b0, 1'b0);

    tv.push_back(v("rst", 1,0,0,0,0, 0,0,0,0,0));
    tv.push_back(v("fill0", 0,1,'h10,0,0, 1,'h10,0,1,0));
    tv.push_back(v("fill1", 0,1,'h11,0,0, 1,'h10,0,2,0));
    tv.push_back(v("fill2", 0,1,'h12,0,0, 1,'h10,0,3,0));
    tv.push_back(v("fill3", 0,1,'h13,0,0, 1,'h10,1,4,0));
    tv.push_back(v("ovf", 0,1,'h14,0,0, 1,'h10,1,4,1));
    tv.push_back(v("ovf_clr", 0,0,0,0,0, 1,'h10,1,4,0));
    tv.push_back(v("drain0", 0,0,0,0,1, 1,'h11,0,3,0));
    tv.push_back(v("drain1", 0,0,0,0,1, 1,'h12,0,2,0));
    tv.push_back(v("drain2", 0,0,0,0,1, 1,'h13,0,1,0));
    tv.push_back(v("drain3", 0,0,0,0,1, 0,0,0,0,0));
    for (int i = 0; i < 10; i++) begin
      tv.push_back(v($sformatf("stream%0d", i), 0,1,14'(32'h20 + i),0,1,
                     1,14'(32'h20 + i),0,1,0));
    end
    tv.push_back(v("stream_end", 0,0,0,0,1, 0,0,0,0,0));
    tv.push_back(v("pre_fl0", 0,1,'h30,0,0, 1,'h30,0,1,0));
    tv.push_back(v("pre_fl1", 0,1,'h31,0,0, 1,'h30,0,2,0));
    tv.push_back(v("pre_fl2", 0,1,'h32,0,0, 1,'h30,0,3,0));
    tv.push_back(v("flush", 0,1,'h33,1,1, 0,0,0,0,0));
    tv.push_back(v("post0", 0,1,'h40,0,0, 1,'h40,0,1,0));
    tv.push_back(v("post1", 0,1,'h41,0,0, 1,'h40,0,2,0));
    tv.push_back(v("rst_mid", 1,1,'h42,1,1, 0,0,0,0,0));
    tv.push_back(v("after_rst", 0,1,'h50,0,0, 1,'h50,0,1,0));
    tv.push_back(v("idle", 0,0,0,0,0, 1,'h50,0,1,0));

    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].iv, tv[i].pc, tv[i].take, tv[i].rdy);
      @(posedge CLK);
      #1;
      cmp({tv[i].nm, ".valid"}, 32'(dvalid), 32'(tv[i].ev));
      cmp({tv[i].nm, ".stall"}, 32'(stall), 32'(tv[i].est));
      cmp({tv[i].nm, ".occ"}, 32'(occ), 32'(tv[i].eocc));
      cmp({tv[i].nm, ".err"}, 32'(derr), 32'(tv[i].eerr));
      if (tv[i].rst) begin
        cmp({tv[i].nm, ".pc"}, 32'(dpc), 32'h0);
        cmp({tv[i].nm, ".instr"}, dinstr, 32'h0);
        cmp({tv[i].nm, ".npc"}, 32'(dnpc), 32'h0);
      end else if (tv[i].ev) begin
        check_head(tv[i].nm, tv[i].epc);
      end
    end

    // Refill to full across the wrap, then push while draining.
    for (int i = 1; i < 4; i++) begin
      drive(1'b0, 1'b1, 14'(32'h50 + i), 1'b0, 1'b0);
      @(posedge CLK);
      #1;
    end
    cmp("refill.occ", 32'(occ), 32'd4);
    cmp("refill.stall", 32'(stall), 32'd1);
    drive(1'b0, 1'b1, 14'h54, 1'b0, 1'b1);
    #1;
    cmp("full_deq.stall_pre", 32'(stall), 32'd1);
    @(posedge CLK);
    #1;
    cmp("full_deq.occ", 32'(occ), 32'd3);
    cmp("full_deq.err", 32'(derr), 32'd1);
    cmp("full_deq.stall", 32'(stall), 32'd0);
    check_head("full_deq", 14'h51);
    drive(1'b0, 1'b0, 14'h0, 1'b0, 1'b1);
    @(posedge CLK);
    #1;
    cmp("tail.err", 32'(derr), 32'd0);
    check_head("tail0", 14'h52);
    @(posedge CLK);
    #1;
    check_head("tail1", 14'h53);
    @(posedge CLK);
    #1;
    cmp("tail.valid", 32'(dvalid), 32'd0);
    cmp("tail.occ", 32'(occ), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction queue between the fetch unit and dispatch. Buffers each valid fetched instruction together with its PC and predicted nPC in a circular FIFO, then presents the oldest entry to dispatch under a valid/ready handshake. When the queue is full it back-pressures fetch through the fetch-unit stall input. On a resolved-PC redirect it flushes every entry it holds.

## Interface
- IQ_DEPTH, 4, number of entries; must be a power of 2, minimum 2
- LOG_IQ_DEPTH, 2, log2(IQ_DEPTH)
- CLK  input  1  clock; all state updates on rising edge
- nRST  input  1  synchronous, active-high reset (1 = reset on next CLK edge)
- from_fetch_ivalid  input  1  fetch unit presents a valid instruction this cycle
- from_fetch_instr  input  32  fetched instruction word (word_t)
- from_fetch_PC  input  14  word-granular PC of instruction (pc_t)
- from_fetch_nPC  input  14  predicted next PC (pc_t)
- from_pipeline_take_resolved  input  1  redirect/flush request
- dispatch_ready  input  1  dispatch accepts head entry this cycle
- to_dispatch_valid  output  1  head entry valid
- to_dispatch_instr  output  32  head instr
- to_dispatch_PC  output  14  head PC
- to_dispatch_nPC  output  14  head nPC
- stall_fetch  output  1  drives core_control_stall_fetch_unit; high when queue is full
- occupancy  output  LOG_IQ_DEPTH+1  current entry count
- DUT_error  output  1  registered error flag

## Operation
- State: entry array, head ptr and tail ptr (LOG_IQ_DEPTH bits each, natural wrap), count (LOG_IQ_DEPTH+1 bits), DUT_error register.
- enq = from_fetch_ivalid & ~full & ~from_pipeline_take_resolved.
- deq = to_dispatch_valid & dispatch_ready & ~from_pipeline_take_resolved.
- full = (count == IQ_DEPTH); empty = (count == 0).
- On enq: write {instr, PC, nPC} at tail; tail += 1.
- On deq: head += 1.
- count update: +1 on enq only, -1 on deq only, unchanged on both or neither.
- Simultaneous enq and deq when non-empty and non-full: both occur, count unchanged.
- When full, enq is blocked. A deq in the same cycle does not allow enq; stall_fetch depends on registered state only.
- Flush (take_resolved = 1): head, tail and count go to 0. Any same-cycle enq or deq is suppressed, and entry contents are don't-care.
- Overflow: from_fetch_ivalid & full & ~take_resolved drops the instruction and sets DUT_error = 1 on the next edge. DUT_error is otherwise 0, i.e. a one-cycle pulse per event.
- Outputs:
  - to_dispatch_valid = ~empty.
  - to_dispatch_instr/PC/nPC = entry[head], combinational read; don't-care when empty.
  - stall_fetch = full.
  - occupancy = count.
- Reset (nRST = 1 at edge): head = tail = count = 0 and DUT_error = 0. Entry array is cleared to 0. Reset has priority over flush and over all traffic.
- Reset values of outputs: to_dispatch_valid = 0, to_dispatch_instr/PC/nPC = 0, stall_fetch = 0, occupancy = 0, DUT_error = 0.

## Timing
- Enqueue-to-visible latency: an entry enqueued on edge N is presented to dispatch during cycle N+1. There is no same-cycle bypass.
- Dequeue: head advances on the edge where valid & ready; the next entry is presented in the following cycle.
- Throughput: one enq plus one deq per cycle in steady state.
- stall_fetch rises in the cycle after the enq that fills the queue. It falls in the cycle after the first deq from full.
- Flush: to_dispatch_valid = 0 in the cycle after take_resolved. The first post-redirect instruction can enq in that same cycle and appears one cycle later.
- There is no combinational path from dispatch_ready or from_fetch_ivalid to stall_fetch.
- Wrap-around: ptrs roll from IQ_DEPTH-1 to 0 with no bubble.

## Test plan
- Reset and fill:
  - Stimulus: assert nRST, release, then push 4 instrs (0x8C010000…0x8C010003, PC 0x10–0x13, nPC PC+1) with dispatch_ready = 0.
  - Required: count 1,2,3,4; stall_fetch = 1 after the 4th edge; head shows PC 0x10.
- Drain and order:
  - Stimulus: from full, dispatch_ready = 1 for 4 cycles.
  - Required: PCs 0x10,0x11,0x12,0x13 in order; valid = 0 after; stall_fetch = 0 after the first deq.
- Streaming and wrap:
  - Stimulus: ivalid and ready both held high for 10 cycles, PC 0x20–0x29.
  - Required: count stays 1 after the first cycle; outputs in order; ptrs wrap without a drop.
- Flush with concurrent traffic:
  - Stimulus: queue holds 3 entries; assert take_resolved with ivalid = 1 and ready = 1.
  - Required: next cycle count = 0 and valid = 0; neither the incoming nor the head instruction is consumed or stored.
- Overflow error:
  - Stimulus: queue full; force ivalid = 1 for one cycle.
  - Required: DUT_error = 1 for exactly one cycle; count stays 4; head unchanged.
- Reset mid-operation:
  - Stimulus: 2 entries held; nRST = 1 together with ivalid = 1 and take_resolved = 1.
  - Required: all outputs return to reset values; no entry retained.
